univ_shift_reg: RTL and testbench

//   Parametrised universal shift register for the sequential multiplier datapath.

---
 rtl/shift_pkg.sv | 24 ++
 rtl/shift_step_unit.sv | 53 +++++
 rtl/univ_shift_reg.sv | 120 ++++++++++++
 tb/tb_univ_shift_reg.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Package: shift_pkg
// Shared encodings for the universal shift register datapath.
//   mode_e  : fill-mode encodings (MODE_LOG / MODE_ARI / MODE_ROT / MODE_LG2)
//   state_e : multi-step shift FSM states (ST_IDLE / ST_RUN / ST_DONE)
//   DIR_R / DIR_L : shift direction constants
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_LOG = 2'b00,
    MODE_ARI = 2'b01,
    MODE_ROT = 2'b10,
    MODE_LG2 = 2'b11   // aliases logical
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic DIR_R = 1'b0;  // toward Q[0]
  localparam logic DIR_L = 1'b1;  // toward Q[W-1]

endpackage

// File: rtl/shift_step_unit.sv
// Module: shift_step_unit
// Combinational one-step shifter shared by the single-step and multi-step paths.
// Optional feature: SHIFT_ROTATE_EN (mode 10 rotates; otherwise mode 10 is logical).
// Ports:
//   q       in   W  current register value
//   dir     in   1  0 = right, 1 = left
//   mode    in   2  fill mode
//   si      in   1  serial input for logical fill
//   q_next  out  W  value after one step
//   out_bit out  1  bit shifted out this step
module shift_step_unit
  import shift_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] q,
  input  logic         dir,
  input  logic [1:0]   mode,
  input  logic         si,
  output logic [W-1:0] q_next,
  output logic         out_bit
);

  logic fill;

  always_comb begin
    fill    = si;
    q_next  = q;
    out_bit = 1'b0;
    if (dir == DIR_L) begin
      out_bit = q[W-1];
      if (mode == MODE_ARI) begin
        fill = 1'b0;
`ifdef SHIFT_ROTATE_EN
      end else if (mode == MODE_ROT) begin
        fill = q[W-1];
`endif
      end
      q_next = {q[W-2:0], fill};
    end else begin
      out_bit = q[0];
      if (mode == MODE_ARI) begin
        fill = q[W-1];   // sign extension
`ifdef SHIFT_ROTATE_EN
      end else if (mode == MODE_ROT) begin
        fill = q[0];
`endif
      end
      q_next = {fill, q[W-1:1]};
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Module: univ_shift_reg
// Universal shift register: parallel load, sync clear, single-step shift and
// multi-step shifts driven by a start/busy/done handshake.
// Optional feature: SHIFT_ROTATE_EN enables rotate for mode 10.
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   clr, load, D      sync clear (aborts a run), parallel load of D
//   shift, dir, mode, si   single-step shift controls / serial input
//   start, shamt      begin multi-step shift of min(shamt, W) steps
//   busy, done        RUN indicator, one-cycle completion pulse
//   Q, so             register contents, last bit shifted out
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int W  = 4,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          load,
  input  logic [W-1:0]  D,
  input  logic          shift,
  input  logic          dir,
  input  logic [1:0]    mode,
  input  logic          si,
  input  logic          start,
  input  logic [CW-1:0] shamt,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  Q,
  output logic          so
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic [1:0]    mode_q, mode_d;
  logic [W-1:0]  q_d;
  logic          so_d;

  logic          step_dir;
  logic [1:0]    step_mode;
  logic [W-1:0]  step_q;
  logic          step_out;
  logic [CW-1:0] shamt_n;

  // During a run the latched direction/mode apply; otherwise the live inputs.
  assign step_dir  = (state_q == ST_RUN) ? dir_q  : dir;
  assign step_mode = (state_q == ST_RUN) ? mode_q : mode;
  assign shamt_n   = (shamt > CW'(W)) ? CW'(W) : shamt;

  shift_step_unit #(.W(W)) u_step (
    .q       (Q),
    .dir     (step_dir),
    .mode    (step_mode),
    .si      (si),
    .q_next  (step_q),
    .out_bit (step_out)
  );

  always_comb begin
    state_d = ST_IDLE;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    q_d     = Q;
    so_d    = so;
    if (state_q == ST_RUN) begin
      if (clr) begin
        q_d  = '0;
        so_d = 1'b0;
        cnt_d = '0;
      end else begin
        q_d   = step_q;
        so_d  = step_out;
        cnt_d = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? ST_DONE : ST_RUN;
      end
    end else begin
      // IDLE and DONE accept commands identically: clr > load > start > shift.
      if (clr) begin
        q_d  = '0;
        so_d = 1'b0;
      end else if (load) begin
        q_d = D;
      end else if (start) begin
        dir_d   = dir;
        mode_d  = mode;
        cnt_d   = shamt_n;
        state_d = (shamt_n == '0) ? ST_DONE : ST_RUN;
      end else if (shift) begin
        q_d  = step_q;
        so_d = step_out;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_R;
      mode_q  <= MODE_LOG;
      Q       <= '0;
      so      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      Q       <= q_d;
      so      <= so_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);
`ifdef SHIFT_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          clr = 0, load = 0, shift = 0, dir = 0, si = 0, start = 0;
  logic [W-1:0]  D = '0;
  logic [1:0]    mode = 2'b00;
  logic [CW-1:0] shamt = '0;
  logic          busy, done, so;
  logic [W-1:0]  Q;

  univ_shift_reg #(.W(W)) dut (
    .clk(clk), .resetn(resetn), .clr(clr), .load(load), .D(D),
    .shift(shift), .dir(dir), .mode(mode), .si(si), .start(start),
    .shamt(shamt), .busy(busy), .done(done), .Q(Q), .so(so)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  int busy_cycles = 0;
  int done_pulses = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register as an integer, run as "steps remaining".
  int m_q = 0, m_so = 0, m_left = 0, m_dir = 0, m_mode = 0;
  bit m_done = 0;

  function automatic void model_step(input int d, input int md, input int s);
    int fill, outb;
    bit ari, rot;
    ari = (md == 1);
    rot = (md == 2) && ROT;
    if (d == 0) begin
      outb = m_q % 2;
      fill = ari ? (m_q >> (W-1)) % 2 : rot ? outb : s;
      m_q  = (m_q >> 1) + fill * (1 << (W-1));
    end else begin
      outb = (m_q >> (W-1)) % 2;
      fill = ari ? 0 : rot ? outb : s;
      m_q  = (m_q * 2 + fill) % (1 << W);
    end
    m_so = outb;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_q = 0; m_so = 0; m_left = 0; m_done = 0;
    end else if (m_left > 0) begin
      if (clr) begin
        m_q = 0; m_so = 0; m_left = 0; m_done = 0;
      end else begin
        model_step(m_dir, m_mode, int'(si));
        m_left = m_left - 1;
        m_done = (m_left == 0);
      end
    end else begin
      m_done = 0;
      if (clr) begin
        m_q = 0; m_so = 0;
      end else if (load) begin
        m_q = int'(D);
      end else if (start) begin
        m_left = (int'(shamt) > W) ? W : int'(shamt);
        m_dir  = int'(dir);
        m_mode = int'(mode);
        m_done = (m_left == 0);
      end else if (shift) begin
        model_step(int'(dir), int'(mode), int'(si));
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_Q", int'(Q), m_q);
      chk("cyc_so", int'(so), m_so);
      chk("cyc_busy", int'(busy), int'(m_left > 0));
      chk("cyc_done", int'(done), int'(m_done));
      if (busy && done) chk("busy_and_done", 1, 0);
      if (busy) busy_cycles++;
      if (done) done_pulses++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1; D = v;
    tick();
    load = 0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_Q", int'(Q), 0);
    chk("rst_so", int'(so), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    resetn = 1;
    cmp_en = 1;
    tick();

    // 1: load 1010, shift right logical si=1
    do_load(4'b1010);
    shift = 1; dir = 0; mode = 2'b00; si = 1;
    tick();
    shift = 0;
    chk("t1_Q", int'(Q), 'b1101);
    chk("t1_so", int'(so), 0);
    chk("t1_model", m_q, 'b1101);

    // 2: 1011, start 3 steps left logical si=0
    do_load(4'b1011);
    start = 1; shamt = 3; dir = 1; mode = 2'b00; si = 0;
    busy_cycles = 0; done_pulses = 0;
    tick();
    start = 0; dir = 0;  // latched values must hold
    tick(); chk("t2_s1", int'(Q), 'b0110);
    tick(); chk("t2_s2", int'(Q), 'b1100);
    tick(); chk("t2_s3", int'(Q), 'b1000);
    chk("t2_so", int'(so), 1);
    tick();
    chk("t2_busy_cyc", busy_cycles, 3);
    chk("t2_done_cnt", done_pulses, 1);

    // 3: 1001, start 2 steps right arithmetic
    do_load(4'b1001);
    start = 1; shamt = 2; dir = 0; mode = 2'b01;
    done_pulses = 0;
    tick();
    start = 0;
    tick(); tick();
    chk("t3_Q", int'(Q), 'b1110);
    chk("t3_so", int'(so), 0);
    chk("t3_done", int'(done), 1);
    tick();
    chk("t3_done_cnt", done_pulses, 1);

    // 4: mode 10 left shift
    do_load(4'b1001);
    shift = 1; mode = 2'b10; dir = 1; si = 0;
    tick();
    shift = 0;
    chk("t4_Q", int'(Q), ROT ? 'b0011 : 'b0010);
    chk("t4_so", int'(so), 1);

    // priority: load beats start in IDLE
    load = 1; D = 4'b0101; start = 1; shamt = 2;
    tick();
    load = 0; start = 0;
    chk("prio_Q", int'(Q), 'b0101);
    chk("prio_busy", int'(busy), 0);

    // 5: shamt 7 clamps to 4; load mid-run is ignored
    do_load(4'b1010);
    start = 1; shamt = 7; dir = 0; mode = 2'b00; si = 1;
    busy_cycles = 0; done_pulses = 0;
    tick();
    start = 0;
    tick(); load = 1; D = 4'b0000;
    tick(); load = 0;
    repeat (4) tick();
    chk("t5_busy_cyc", busy_cycles, 4);
    chk("t5_done_cnt", done_pulses, 1);
    chk("t5_Q", int'(Q), 'b1111);

    // 5b: shamt 0
    busy_cycles = 0; done_pulses = 0;
    start = 1; shamt = 0;
    tick();
    start = 0;
    chk("t5b_done", int'(done), 1);
    chk("t5b_busy", int'(busy), 0);
    tick();
    chk("t5b_busy_cyc", busy_cycles, 0);
    chk("t5b_done_cnt", done_pulses, 1);
    chk("t5b_Q", int'(Q), 'b1111);

    // 6a: clr mid-run
    do_load(4'b1111);
    start = 1; shamt = 4; dir = 1; mode = 2'b00; si = 0;
    done_pulses = 0;
    tick();
    start = 0;
    tick();
    chk("t6a_step1", int'(Q), 'b1110);
    clr = 1;
    tick();
    clr = 0;
    chk("t6a_Q", int'(Q), 0);
    chk("t6a_so", int'(so), 0);
    chk("t6a_busy", int'(busy), 0);
    tick(); tick(); tick();
    chk("t6a_done_cnt", done_pulses, 0);

    // 6b: async reset mid-run
    do_load(4'b0110);
    start = 1; shamt = 3; dir = 0; mode = 2'b00; si = 1;
    done_pulses = 0;
    tick();
    start = 0;
    tick();
    #2 resetn = 0;
    #1;
    chk("t6b_Q", int'(Q), 0);
    chk("t6b_so", int'(so), 0);
    chk("t6b_busy", int'(busy), 0);
    chk("t6b_done", int'(done), 0);
    tick();
    resetn = 1;
    tick(); tick(); tick(); tick();
    chk("t6b_done_cnt", done_pulses, 0);

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
